// File: rtl/can_bus_if.sv
// can_bus_if -- bundles the CAN bus interconnect signals.
//   slave  : interconnect side (takes node TX and config, drives RX/monitors)
//   master : environment side (node controllers, fault/monitor control)
// Signals: tx_i/node_en_i/delay_i per node, rx_o per node, bus_o,
//   bit_time_i, fault_* controls and status, bus_idle_o, edge_cnt_o, edge_clr_i.
interface can_bus_if #(
  parameter int NUM_NODES = 3,
  parameter int DELAY_W   = 5
);
  logic [NUM_NODES-1:0]         tx_i;
  logic [NUM_NODES-1:0]         node_en_i;
  logic [NUM_NODES*DELAY_W-1:0] delay_i;
  logic [NUM_NODES-1:0]         rx_o;
  logic                         bus_o;
  logic [15:0]                  bit_time_i;
  logic [1:0]                   fault_mode_i;
  logic                         fault_arm_i;
  logic [7:0]                   fault_edge_i;
  logic [15:0]                  fault_offset_i;
  logic [15:0]                  fault_len_i;
  logic                         fault_busy_o;
  logic                         fault_done_o;
  logic                         bus_idle_o;
  logic [15:0]                  edge_cnt_o;
  logic                         edge_clr_i;

  modport slave (
    input  tx_i, node_en_i, delay_i, bit_time_i, fault_mode_i, fault_arm_i,
           fault_edge_i, fault_offset_i, fault_len_i, edge_clr_i,
    output rx_o, bus_o, fault_busy_o, fault_done_o, bus_idle_o, edge_cnt_o
  );

  modport master (
    output tx_i, node_en_i, delay_i, bit_time_i, fault_mode_i, fault_arm_i,
           fault_edge_i, fault_offset_i, fault_len_i, edge_clr_i,
    input  rx_o, bus_o, fault_busy_o, fault_done_o, bus_idle_o, edge_cnt_o
  );
endinterface

// File: rtl/can_bus_interconnect.sv
// can_bus_interconnect -- wired-AND CAN bus model with per-node RX delay,
// armed fault injection, idle detection and falling-edge counting.
// Ports: clk_i, rst_n_i (async, active low), bus (can_bus_if.slave).

// Per-node RX tap: picks the delayed bus value out of the shared history.
module can_rx_tap #(
  parameter int MAX_DELAY = 16,
  parameter int DELAY_W   = 5
) (
  input  logic                 i_en,
  input  logic [DELAY_W-1:0]   i_delay,
  input  logic                 i_bus,
  input  logic [MAX_DELAY-1:0] i_hist,
  output logic                 o_rx
);
  localparam int IDX_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [DELAY_W-1:0] w_dm1;
  logic [IDX_W-1:0]   w_idx;

  // Delays beyond the history depth clamp to the oldest entry.
  assign w_dm1 = i_delay - DELAY_W'(1);
  assign w_idx = (int'(i_delay) > MAX_DELAY) ? IDX_W'(MAX_DELAY-1) : IDX_W'(w_dm1);

  always_comb begin
    o_rx = 1'b1;
    if (i_en) o_rx = (i_delay == '0) ? i_bus : i_hist[w_idx];
  end
endmodule

module can_bus_interconnect #(
  parameter int NUM_NODES = 3,
  parameter int MAX_DELAY = 16,
  parameter int DELAY_W   = 5,
  parameter int IDLE_BITS = 11
) (
  input  logic    clk_i,
  input  logic    rst_n_i,
  can_bus_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           r_mode;
  logic [15:0]          r_offset, r_len;
  logic [7:0]           r_ec;
  logic [15:0]          r_oc, r_lc;
  logic                 r_done;
  logic [MAX_DELAY-1:0] r_hist;
  logic                 r_prev_bus, r_prev_raw;
  logic [15:0]          r_edge_cnt;
  logic [23:0]          r_idle_cnt;
  logic                 r_idle;

  logic                 w_raw, w_bus, w_edge, w_raw_edge;
  logic [7:0]           w_edge_tgt;
  logic [15:0]          w_len_m1;
  logic [23:0]          w_prod, w_thresh;
  logic [NUM_NODES-1:0] w_rx;

  // Disabled nodes look recessive on the wire.
  assign w_raw = &(bus.tx_i | ~bus.node_en_i);

  always_comb begin
    w_bus = w_raw;
    if (r_state == S_ACTIVE) begin
      case (r_mode)
        2'b01:   w_bus = 1'b0;
        2'b10:   w_bus = 1'b1;
        2'b11:   w_bus = ~w_raw;
        default: w_bus = w_raw;
      endcase
    end
  end

  assign w_edge     = r_prev_bus & ~w_bus;
  // Trigger edges are counted on the undisturbed wire so the fault cannot retrigger itself.
  assign w_raw_edge = r_prev_raw & ~w_raw;
  assign w_edge_tgt = (bus.fault_edge_i == 8'd0) ? 8'd1 : bus.fault_edge_i;
  assign w_len_m1   = (r_len == 16'd0) ? 16'd0 : r_len - 16'd1;

  // Zero bit time degenerates to "recessive for at least one cycle".
  assign w_prod   = 24'(IDLE_BITS) * {8'd0, bus.bit_time_i};
  assign w_thresh = (w_prod == 24'd0) ? 24'd1 : w_prod;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hist     <= '1;
      r_prev_bus <= 1'b1;
      r_prev_raw <= 1'b1;
      r_edge_cnt <= '0;
      r_idle_cnt <= '0;
      r_idle     <= 1'b0;
    end else begin
      r_hist[0] <= w_bus;
      for (int k = 1; k < MAX_DELAY; k++) r_hist[k] <= r_hist[k-1];
      r_prev_bus <= w_bus;
      r_prev_raw <= w_raw;
      if (bus.edge_clr_i)  r_edge_cnt <= '0;
      else if (w_edge)     r_edge_cnt <= r_edge_cnt + 16'd1;
      if (!w_bus)                 r_idle_cnt <= '0;
      else if (r_idle_cnt != '1)  r_idle_cnt <= r_idle_cnt + 24'd1;
      r_idle <= (r_idle_cnt >= w_thresh);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_mode   <= 2'b00;
      r_offset <= '0;
      r_len    <= '0;
      r_ec     <= '0;
      r_oc     <= '0;
      r_lc     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.fault_arm_i && bus.fault_mode_i != 2'b00) begin
          r_state  <= S_ARMED;
          r_ec     <= '0;
          r_mode   <= bus.fault_mode_i;
          r_offset <= bus.fault_offset_i;
          r_len    <= bus.fault_len_i;
        end
        S_ARMED: if (w_raw_edge) begin
          if (r_ec + 8'd1 == w_edge_tgt) begin
            // Offset counts cycles after the trigger edge; 0 goes straight to ACTIVE.
            if (r_offset == 16'd0) begin
              r_state <= S_ACTIVE;
              r_lc    <= '0;
            end else begin
              r_state <= S_WAIT;
              r_oc    <= 16'd1;
            end
          end else begin
            r_ec <= r_ec + 8'd1;
          end
        end
        S_WAIT: begin
          if (r_oc == r_offset) begin
            r_state <= S_ACTIVE;
            r_lc    <= '0;
          end else begin
            r_oc <= r_oc + 16'd1;
          end
        end
        default: begin
          if (r_lc == w_len_m1) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_lc <= r_lc + 16'd1;
          end
        end
      endcase
    end
  end

  genvar n;
  generate
    for (n = 0; n < NUM_NODES; n++) begin : g_tap
      can_rx_tap #(.MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W)) u_tap (
        .i_en    (bus.node_en_i[n]),
        .i_delay (bus.delay_i[n*DELAY_W +: DELAY_W]),
        .i_bus   (w_bus),
        .i_hist  (r_hist),
        .o_rx    (w_rx[n])
      );
    end
  endgenerate

  assign bus.rx_o         = w_rx;
  assign bus.bus_o        = w_bus;
  assign bus.fault_busy_o = (r_state != S_IDLE);
  assign bus.fault_done_o = r_done;
  assign bus.bus_idle_o   = r_idle;
  assign bus.edge_cnt_o   = r_edge_cnt;
endmodule

// File: tb/tb_can_bus_interconnect.sv
// Scoreboard bench: stimulus pushes (cycle, signal, value) expectations;
// a negedge monitor compares every expectation due in the current cycle.
module tb_can_bus_interconnect;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct { int cyc; int id; logic [15:0] val; } exp_t;
  exp_t q[$];

  can_bus_if #(.NUM_NODES(3), .DELAY_W(5)) cb();

  can_bus_interconnect #(.NUM_NODES(3), .MAX_DELAY(16), .DELAY_W(5), .IDLE_BITS(11)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (cb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int BUS = 0, RX0 = 1, RX1 = 2, RX2 = 3, BUSY = 4, DONE = 5, IDLE = 6, EDGE = 7;

  function automatic string nm(input int id);
    case (id)
      BUS: return "bus_o";   RX0: return "rx_o[0]"; RX1: return "rx_o[1]";
      RX2: return "rx_o[2]"; BUSY: return "fault_busy_o"; DONE: return "fault_done_o";
      IDLE: return "bus_idle_o"; default: return "edge_cnt_o";
    endcase
  endfunction

  function automatic logic [15:0] act(input int id);
    case (id)
      BUS:  return {15'd0, cb.bus_o};
      RX0:  return {15'd0, cb.rx_o[0]};
      RX1:  return {15'd0, cb.rx_o[1]};
      RX2:  return {15'd0, cb.rx_o[2]};
      BUSY: return {15'd0, cb.fault_busy_o};
      DONE: return {15'd0, cb.fault_done_o};
      IDLE: return {15'd0, cb.bus_idle_o};
      default: return cb.edge_cnt_o;
    endcase
  endfunction

  // Monitor: consume every expectation due now; anything overdue was never sampled.
  always @(negedge clk) begin
    logic [15:0] a;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        n_cmp++;
        a = act(q[i].id);
        if (a !== q[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %0h expected %0h", nm(q[i].id), cyc, a, q[i].val);
        end
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cyc %0d: expectation never sampled", nm(q[i].id), q[i].cyc);
        q.delete(i);
      end
    end
  end

  task automatic ex(input int c, input int id, input logic [15:0] v);
    exp_t e;
    e.cyc = c; e.id = id; e.val = v;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c, R, D, C, A, T, T3, U, Z, Aa, E2, P, B, E;

  initial begin
    cb.tx_i = 3'b111; cb.node_en_i = 3'b111; cb.delay_i = '0;
    cb.bit_time_i = 16'd10; cb.fault_mode_i = 2'b00; cb.fault_arm_i = 1'b0;
    cb.fault_edge_i = 8'd0; cb.fault_offset_i = 16'd0; cb.fault_len_i = 16'd0;
    cb.edge_clr_i = 1'b0;

    // Reset state
    step(2); c = cyc;
    ex(c, BUS, 1); ex(c, RX0, 1); ex(c, RX1, 1); ex(c, RX2, 1);
    ex(c, BUSY, 0); ex(c, DONE, 0); ex(c, IDLE, 0); ex(c, EDGE, 0);

    // Idle detection with bit_time 10 from reset release
    rst_n = 1'b1; R = cyc;
    ex(R + 110, IDLE, 0); ex(R + 111, IDLE, 1);
    step(115); D = cyc;
    cb.tx_i = 3'b110;
    ex(D, BUS, 0); ex(D, EDGE, 0); ex(D + 1, EDGE, 1);
    ex(D + 1, IDLE, 1); ex(D + 2, IDLE, 0);
    ex(D + 111, IDLE, 0); ex(D + 112, IDLE, 1);
    step(1); cb.tx_i = 3'b111;
    step(115);

    // Clear wins over a simultaneous edge
    C = cyc; cb.tx_i = 3'b110; cb.edge_clr_i = 1'b1;
    ex(C, EDGE, 1); ex(C + 1, EDGE, 0);
    step(1); cb.tx_i = 3'b111; cb.edge_clr_i = 1'b0;
    step(3);

    // Node1 dominant for 5 cycles, all delays 0
    A = cyc; cb.tx_i = 3'b101;
    for (int k = 0; k < 5; k++) begin
      ex(A + k, BUS, 0); ex(A + k, RX0, 0); ex(A + k, RX1, 0); ex(A + k, RX2, 0);
    end
    ex(A + 5, BUS, 1); ex(A + 5, RX1, 1); ex(A + 5, EDGE, 1);
    step(5); cb.tx_i = 3'b111;
    step(2);

    // Delays 0/3/16
    cb.delay_i = {5'd16, 5'd3, 5'd0};
    step(20); T = cyc; cb.tx_i = 3'b101;
    ex(T, RX0, 0); ex(T + 1, RX0, 1);
    ex(T + 2, RX1, 1); ex(T + 3, RX1, 0); ex(T + 4, RX1, 1);
    ex(T + 15, RX2, 1); ex(T + 16, RX2, 0); ex(T + 17, RX2, 1);
    step(1); cb.tx_i = 3'b111;
    step(20);
    // Delay 20 clamps to 16
    cb.delay_i = {5'd20, 5'd3, 5'd0};
    step(2); T3 = cyc; cb.tx_i = 3'b110;
    ex(T3 + 3, RX1, 0);
    ex(T3 + 15, RX2, 1); ex(T3 + 16, RX2, 0); ex(T3 + 17, RX2, 1);
    step(1); cb.tx_i = 3'b111;
    step(20);

    // Disabled node is ignored and its RX held high
    U = cyc; cb.node_en_i = 3'b101; cb.tx_i = 3'b101;
    ex(U, BUS, 1); ex(U + 3, BUS, 1); ex(U, RX1, 1); ex(U + 4, RX1, 1);
    step(6); cb.tx_i = 3'b111; cb.node_en_i = 3'b111; cb.delay_i = '0;
    step(2);

    // Arm with mode 00 is ignored
    Z = cyc; cb.fault_arm_i = 1'b1; cb.fault_mode_i = 2'b00;
    ex(Z + 1, BUSY, 0); ex(Z + 2, BUSY, 0);
    step(1); cb.fault_arm_i = 1'b0;
    step(2);

    // Force dominant: edge 2, offset 10, len 4; later input changes must not matter
    Aa = cyc; cb.fault_arm_i = 1'b1; cb.fault_mode_i = 2'b01;
    cb.fault_edge_i = 8'd2; cb.fault_offset_i = 16'd10; cb.fault_len_i = 16'd4;
    ex(Aa, BUSY, 0); ex(Aa + 1, BUSY, 1);
    step(1); cb.fault_arm_i = 1'b0; cb.fault_mode_i = 2'b10;
    cb.fault_offset_i = 16'd3; cb.fault_len_i = 16'd9;
    step(2); cb.tx_i = 3'b011;
    step(1); cb.tx_i = 3'b111;
    step(2); E2 = cyc; cb.tx_i = 3'b011;
    ex(E2 + 1, BUSY, 1); ex(E2 + 10, BUS, 1);
    for (int k = 11; k <= 14; k++) ex(E2 + k, BUS, 0);
    ex(E2 + 15, BUS, 1);
    ex(E2 + 14, BUSY, 1); ex(E2 + 15, BUSY, 0);
    ex(E2 + 14, DONE, 0); ex(E2 + 15, DONE, 1); ex(E2 + 16, DONE, 0);
    step(1); cb.tx_i = 3'b111;
    step(2); cb.fault_arm_i = 1'b1; cb.fault_mode_i = 2'b10;
    step(1); cb.fault_arm_i = 1'b0;
    step(20);

    // bit_time 0: idle means recessive for at least one cycle
    cb.bit_time_i = 16'd0;
    step(2); P = cyc; cb.tx_i = 3'b110;
    ex(P + 1, IDLE, 1); ex(P + 2, IDLE, 0); ex(P + 3, IDLE, 1);
    step(1); cb.tx_i = 3'b111;
    step(5); cb.bit_time_i = 16'd10;

    // Invert with edge 0 and offset 0, then reset during ACTIVE
    B = cyc; cb.fault_arm_i = 1'b1; cb.fault_mode_i = 2'b11;
    cb.fault_edge_i = 8'd0; cb.fault_offset_i = 16'd0; cb.fault_len_i = 16'd20;
    step(1); cb.fault_arm_i = 1'b0;
    step(1); E = cyc; cb.tx_i = 3'b110;
    ex(E, BUS, 0); ex(E + 1, BUS, 0); ex(E + 2, BUS, 0); ex(E + 2, BUSY, 1);
    step(1); cb.tx_i = 3'b111;
    step(2); rst_n = 1'b0;
    ex(E + 3, BUS, 1); ex(E + 3, BUSY, 0); ex(E + 4, EDGE, 0);
    for (int k = 3; k <= 6; k++) ex(E + k, DONE, 0);
    ex(E + 7, BUSY, 0);
    step(2); rst_n = 1'b1;
    step(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
